// File: rtl/sen_axis_packer.sv
// Re-emits the lane-aligned sensor pixel stream as AXI4-Stream video (12->16 bit pad, tuser = SOF, tlast = EOL).
// Beats pass through a one-beat hold register into a FWFT line FIFO; lines that cannot fit drop the rest of the frame.
module sen_axis_packer #(
  parameter int D          = 4,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic            px_clk,
  input  logic            px_reset_n,
  input  logic [12*D-1:0] sen_din,
  input  logic            sen_en_in,
  input  logic            sen_vs_in,
  input  logic            sen_lock_in,
  input  logic            enable,
  input  logic [15:0]     ACTIVE_WIDTH,
  input  logic            clr_stat,
  output logic [16*D-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tuser,
  output logic            m_axis_tlast,
  output logic [15:0]     frame_cnt,
  output logic [15:0]     drop_cnt,
  output logic            line_err
);
  localparam int FW = 16*D + 2;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} state_t;

  state_t          state_q, state_d;
  logic            vs_q, vs_d, en_q, en_d;
  logic            hold_vld_q, hold_vld_d, hold_user_q, hold_user_d;
  logic [16*D-1:0] hold_dat_q, hold_dat_d, pad_dat;
  logic            arm_q, arm_d, line_q, line_d, line_err_q, line_err_d;
  logic [15:0]     beat_cnt_q, beat_cnt_d, frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [FW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     level_q, level_d;
  logic            fifo_wr, fifo_rd, fifo_vld;
  logic [FW-1:0]   fifo_wr_dat, fifo_rd_dat;
  logic            vs_rise, en_rise, vs_arm, act_eff, room, admit, reject, cont;
  logic            long_beat, short_end, frame_inc, drop_inc;
  logic [31:0]     free_space;

  // act_eff is the post-frame-edge view, so a beat coinciding with a vs edge belongs to the new frame.
  assign vs_rise    = sen_vs_in && !vs_q;
  assign en_rise    = sen_en_in && !en_q;
  assign vs_arm     = vs_rise && sen_lock_in && (state_q != IDLE);
  assign act_eff    = sen_lock_in && (state_q != IDLE) && (vs_rise ? enable : (state_q == ACTIVE));
  assign free_space = 32'(FIFO_DEPTH) - 32'(level_q) - 32'(hold_vld_q);
  assign room       = free_space >= 32'(ACTIVE_WIDTH) + 32'd1;
  assign admit      = act_eff && en_rise && room;
  assign reject     = act_eff && en_rise && !room;
  assign cont       = act_eff && sen_en_in && !en_rise && line_q && (beat_cnt_q < ACTIVE_WIDTH);
  assign long_beat  = act_eff && sen_en_in && !en_rise && line_q && (beat_cnt_q >= ACTIVE_WIDTH);
  assign short_end  = sen_lock_in && !sen_en_in && line_q && (beat_cnt_q < ACTIVE_WIDTH);
  assign frame_inc  = vs_rise && sen_lock_in && (state_q == ACTIVE);
  assign drop_inc   = reject || ((state_q == ACTIVE) && !sen_lock_in);

  assign fifo_vld    = (level_q != '0);
  assign fifo_rd     = fifo_vld && m_axis_tready;
  assign fifo_wr     = hold_vld_q;
  assign fifo_rd_dat = mem_q[rd_ptr_q];

  always_ff @(posedge px_clk) begin
    if (!px_reset_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)   state_d = sen_lock_in ? WAIT_VS : IDLE;
    else if (!sen_lock_in) state_d = IDLE;
    else if (reject)       state_d = DROP;
    else if (vs_rise)      state_d = enable ? ACTIVE : WAIT_VS;
  end

  always_comb begin
    vs_d    = sen_vs_in;
    en_d    = sen_en_in;
    pad_dat = '0;
    for (int k = 0; k < D; k++) pad_dat[16*k +: 16] = {4'b0, sen_din[12*k +: 12]};
    hold_vld_d  = admit || cont;
    hold_dat_d  = hold_vld_d ? pad_dat : hold_dat_q;
    hold_user_d = hold_vld_d ? (arm_q || vs_arm) : hold_user_q;
    arm_d       = hold_vld_d ? 1'b0 : (arm_q || vs_arm);
    line_d      = admit || (line_q && act_eff && sen_en_in);
    beat_cnt_d  = admit ? 16'd1 : (cont ? beat_cnt_q + 16'd1 : beat_cnt_q);
    // The held beat closes the line whenever no continuing beat replaces it.
    fifo_wr_dat = {hold_user_q, !cont, hold_dat_q};
    wr_ptr_d    = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d     = level_q;
    if (fifo_wr && !fifo_rd)      level_d = level_q + 1'b1;
    else if (!fifo_wr && fifo_rd) level_d = level_q - 1'b1;
    frame_cnt_d = clr_stat ? 16'd0 : frame_cnt_q + {15'd0, frame_inc};
    drop_cnt_d  = clr_stat ? 16'd0 : drop_cnt_q + {15'd0, drop_inc};
    line_err_d  = clr_stat ? 1'b0 : (line_err_q || long_beat || short_end);
  end

  always_ff @(posedge px_clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= fifo_wr_dat;
  end

  always_ff @(posedge px_clk) begin
    if (!px_reset_n) begin
      vs_q        <= 1'b0;
      en_q        <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_user_q <= 1'b0;
      hold_dat_q  <= '0;
      arm_q       <= 1'b0;
      line_q      <= 1'b0;
      beat_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      line_err_q  <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      en_q        <= en_d;
      hold_vld_q  <= hold_vld_d;
      hold_user_q <= hold_user_d;
      hold_dat_q  <= hold_dat_d;
      arm_q       <= arm_d;
      line_q      <= line_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      line_err_q  <= line_err_d;
    end
  end

  assign m_axis_tvalid = fifo_vld;
  assign m_axis_tdata  = fifo_vld ? fifo_rd_dat[16*D-1:0] : '0;
  assign m_axis_tlast  = fifo_vld && fifo_rd_dat[16*D];
  assign m_axis_tuser  = fifo_vld && fifo_rd_dat[16*D+1];
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign line_err      = line_err_q;
endmodule
